// File: rtl/ag32gbd_line_capture.sv
// Camera line capture: buffers the pixel stream in a small FIFO and feeds the
// double-buffered BRAM controller's edge-triggered write port, flipping buffers per line.
module ag32gbd_line_capture #(
  parameter int unsigned LINE_PIXELS = 128,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned REQ_HIGH    = 3,
  parameter int unsigned REQ_LOW     = 2,
  parameter int unsigned FLIP_SETTLE = 12
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       line_start,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic [7:0] BufferWriteData,
  output logic [9:0] BufferWriteOffset,
  output logic       RequestWriteBuffer,
  output logic       FlipBuffer,
  output logic       line_done,
  output logic       overflow,
  output logic       line_lost,
  output logic       busy
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntMax = (FLIP_SETTLE > REQ_HIGH) ?
                                   ((FLIP_SETTLE > REQ_LOW) ? FLIP_SETTLE : REQ_LOW) :
                                   ((REQ_HIGH > REQ_LOW) ? REQ_HIGH : REQ_LOW);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // Index LINE_PIXELS means "line complete": further pixels are ignored.
  localparam logic [8:0] EndIdx  = 9'(LINE_PIXELS);
  localparam logic [8:0] LastIdx = 9'(LINE_PIXELS - 1);

  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] ReqHiEnd  = CntW'(REQ_HIGH - 1);
  localparam logic [CntW-1:0] ReqLoEnd  = CntW'(REQ_LOW - 1);
  localparam logic [CntW-1:0] SettleEnd = CntW'(FLIP_SETTLE - 1);

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] idx;
    logic       last;
  } entryT;

  typedef enum logic [1:0] {StIdle, StReq, StGap, StFlip} stateE;

  // Pixel intake
  logic [8:0]      idxQ, idxD, curIdx;
  logic            inRange, isLast, full, empty;
  logic            push, pop, dropPix, lineCut;
  logic            overflowQ, lineLostQ;
  entryT           newEntry, headEntry;
  entryT           fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtrQ, rdPtrQ;
  logic [PtrW:0]   countQ;

  always_comb begin
    curIdx   = line_start ? 9'd0 : idxQ;
    inRange  = curIdx < EndIdx;
    isLast   = curIdx == LastIdx;
    full     = countQ == FullCount;
    empty    = countQ == '0;
    push     = pix_valid && inRange && !full;
    dropPix  = pix_valid && inRange && full;
    // A new line while the old one is still partial means the old one never flips.
    lineCut  = line_start && (idxQ != 9'd0) && (idxQ != EndIdx);
    newEntry = '{data: pix_data, idx: curIdx[7:0], last: isLast};
    idxD     = idxQ;
    if (line_start) begin
      idxD = 9'd0;
    end
    if (pix_valid && inRange) begin
      idxD = curIdx + 9'd1;
    end
  end

  assign headEntry = fifoMem[rdPtrQ];

  always_ff @(posedge sys_clock) begin
    if (push) begin
      fifoMem[wrPtrQ] <= newEntry;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      idxQ      <= '0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
      lineLostQ <= 1'b0;
    end else begin
      idxQ      <= idxD;
      overflowQ <= overflowQ | dropPix;
      lineLostQ <= lineLostQ | (dropPix & isLast) | lineCut;
      if (push) begin
        wrPtrQ <= wrPtrQ + PtrW'(1);
      end
      if (pop) begin
        rdPtrQ <= rdPtrQ + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   countQ <= countQ + (PtrW + 1)'(1);
        2'b01:   countQ <= countQ - (PtrW + 1)'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  // Write FSM
  stateE           stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic            flipQ, flipD;
  logic            reqQ, doneQ, lastQ;
  logic [7:0]      dataQ;
  logic [9:0]      offsetQ;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    flipD  = flipQ;
    pop    = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (!empty) begin
          pop    = 1'b1;
          stateD = StReq;
          cntD   = '0;
        end
      end
      StReq: begin
        if (cntQ == ReqHiEnd) begin
          stateD = StGap;
          cntD   = '0;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      StGap: begin
        if (cntQ == ReqLoEnd) begin
          cntD = '0;
          if (lastQ) begin
            flipD  = ~flipQ;
            stateD = StFlip;
          end else begin
            stateD = StIdle;
          end
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      StFlip: begin
        // Nothing pops here so the next line lands in the freshly selected buffer.
        if (cntQ == SettleEnd) begin
          stateD = StIdle;
          cntD   = '0;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      default: begin
        stateD = StIdle;
        cntD   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      flipQ   <= 1'b0;
      reqQ    <= 1'b0;
      doneQ   <= 1'b0;
      lastQ   <= 1'b0;
      dataQ   <= '0;
      offsetQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      flipQ  <= flipD;
      reqQ   <= stateD == StReq;
      doneQ  <= (stateD == StFlip) && (cntD == SettleEnd);
      if (pop) begin
        dataQ   <= headEntry.data;
        offsetQ <= {2'b00, headEntry.idx};
        lastQ   <= headEntry.last;
      end
    end
  end

  assign BufferWriteData    = dataQ;
  assign BufferWriteOffset  = offsetQ;
  assign RequestWriteBuffer = reqQ;
  assign FlipBuffer         = flipQ;
  assign line_done          = doneQ;
  assign overflow           = overflowQ;
  assign line_lost          = lineLostQ;
  assign busy               = !empty || (stateQ != StIdle);

endmodule

// File: tb/tb_ag32gbd_line_capture.sv
// Scoreboard bench for ag32gbd_line_capture: stimulus queues expected writes,
// a negedge monitor checks each request rising edge and records flip/done timing.
module tb_ag32gbd_line_capture;

  localparam int LinePixels = 128;
  localparam int ReqLow     = 2;
  localparam int FlipSettle = 12;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic       line_start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [7:0] BufferWriteData;
  logic [9:0] BufferWriteOffset;
  logic       RequestWriteBuffer;
  logic       FlipBuffer;
  logic       line_done;
  logic       overflow;
  logic       line_lost;
  logic       busy;

  ag32gbd_line_capture #(
    .LINE_PIXELS(LinePixels),
    .FIFO_DEPTH (8),
    .REQ_HIGH   (3),
    .REQ_LOW    (ReqLow),
    .FLIP_SETTLE(FlipSettle)
  ) dut (
    .sys_clock         (sys_clock),
    .reset             (reset),
    .line_start        (line_start),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .BufferWriteData   (BufferWriteData),
    .BufferWriteOffset (BufferWriteOffset),
    .RequestWriteBuffer(RequestWriteBuffer),
    .FlipBuffer        (FlipBuffer),
    .line_done         (line_done),
    .overflow          (overflow),
    .line_lost         (line_lost),
    .busy              (busy)
  );

  always #5 sys_clock = ~sys_clock;

  int tests = 0;
  int fails = 0;

  logic [17:0] expQ[$];  // {offset, data}
  logic [17:0] monE;

  int   cyc = 0, rises = 0, flips = 0, dones = 0;
  int   fallCyc = 0, flipCyc = 0, doneCyc = 0, risesAtFlip = 0;
  logic doneArmed = 1'b0;
  logic prevReq = 1'b0, prevFlip = 1'b0;
  int   firstFlipGap = -1, firstDoneGap = -1, firstSettleRises = -1, firstRiseGap = -1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expectWrite(input int off, input logic [7:0] d);
    expQ.push_back({10'(off), d});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic drive(input logic ls, input logic pv, input logic [7:0] d);
    line_start = ls;
    pix_valid  = pv;
    pix_data   = d;
    @(posedge sys_clock);
    #1;
    line_start = 1'b0;
    pix_valid  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    firstFlipGap     = -1;
    firstDoneGap     = -1;
    firstSettleRises = -1;
    firstRiseGap     = -1;
    doneArmed        = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    idle(2);
    while (busy && n < 3000) begin
      idle(1);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic waitDone(input int target, input string name);
    int n;
    n = 0;
    while (dones < target && n < 3000) begin
      idle(1);
      n++;
    end
    check(name, dones, target);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge sys_clock);
      cyc++;
      if (!reset) begin
        if (RequestWriteBuffer && !prevReq) begin
          rises++;
          if (doneArmed) begin
            if (firstRiseGap < 0) firstRiseGap = cyc - doneCyc;
            doneArmed = 1'b0;
          end
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got offset %0d data 0x%02h, expected no write",
                     BufferWriteOffset, BufferWriteData);
          end else begin
            monE = expQ.pop_front();
            check("write_offset", int'(BufferWriteOffset), int'(monE[17:8]));
            check("write_data", int'(BufferWriteData), int'(monE[7:0]));
          end
        end
        if (!RequestWriteBuffer && prevReq) fallCyc = cyc;
        if (FlipBuffer !== prevFlip) begin
          flips++;
          if (firstFlipGap < 0) firstFlipGap = cyc - fallCyc;
          flipCyc     = cyc;
          risesAtFlip = rises;
        end
        if (line_done) begin
          dones++;
          doneCyc   = cyc;
          doneArmed = 1'b1;
          if (firstDoneGap < 0) begin
            firstDoneGap     = cyc - flipCyc;
            firstSettleRises = rises - risesAtFlip;
          end
        end
      end
      prevReq  = RequestWriteBuffer;
      prevFlip = FlipBuffer;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, f0, d0, n;
    reset      = 1'b1;
    line_start = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = 8'h00;
    idle(3);
    reset = 1'b0;

    check("rst_data", int'(BufferWriteData), 0);
    check("rst_offset", int'(BufferWriteOffset), 0);
    check("rst_req", int'(RequestWriteBuffer), 0);
    check("rst_flip", int'(FlipBuffer), 0);
    check("rst_line_done", int'(line_done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_line_lost", int'(line_lost), 0);
    check("rst_busy", int'(busy), 0);

    // Nominal line, then line 2 starting right away so its pixels arrive during FLIP.
    r0 = rises;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < LinePixels; i++) begin
      expectWrite(i, 8'(i));
      drive(1'b0, 1'b1, 8'(i));
      if (i < LinePixels - 1) idle(7);
    end
    for (int i = 0; i < LinePixels; i++) begin
      expectWrite(i, 8'(255 - i));
      drive(i == 0, 1'b1, 8'(255 - i));
      if (i == 64) check("flip_after_line1", int'(FlipBuffer), 1);
      if (i < LinePixels - 1) idle(7);
    end
    waitDone(2, "done_count_lines12");
    waitIdle("idle_after_lines12");
    check("flip_gap_after_req_fall", firstFlipGap, ReqLow);
    check("done_after_flip", firstDoneGap, FlipSettle - 1);
    check("req_edges_during_settle", firstSettleRises, 0);
    check("line2_first_req_after_done", firstRiseGap, 2);
    check("writes_lines12", rises - r0, 2 * LinePixels);
    check("flips_lines12", flips, 2);
    check("flip_level_lines12", int'(FlipBuffer), 0);
    check("overflow_lines12", int'(overflow), 0);
    check("line_lost_lines12", int'(line_lost), 0);
    check("pending_lines12", expQ.size(), 0);

    // Burst overflow: 20 back-to-back pixels, only c0..c9 and c14 fit.
    r0 = rises;
    f0 = flips;
    drive(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      if (c < 10 || c == 14) expectWrite(c, 8'(8'h40 + c));
      drive(1'b0, 1'b1, 8'(8'h40 + c));
    end
    waitIdle("idle_after_burst");
    check("burst_writes", rises - r0, 11);
    check("burst_overflow", int'(overflow), 1);
    check("burst_line_lost", int'(line_lost), 0);
    check("burst_no_flip", flips - f0, 0);
    check("burst_pending", expQ.size(), 0);

    // Short line followed by a full line.
    doReset();
    r0 = rises;
    f0 = flips;
    d0 = dones;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 50; i++) begin
      expectWrite(i, 8'(8'h80 + i));
      drive(1'b0, 1'b1, 8'(8'h80 + i));
      idle(7);
    end
    check("short_lost_before_cut", int'(line_lost), 0);
    drive(1'b1, 1'b0, 8'h00);
    check("short_lost_after_cut", int'(line_lost), 1);
    for (int i = 0; i < LinePixels; i++) begin
      expectWrite(i, 8'(i) ^ 8'h3C);
      drive(1'b0, 1'b1, 8'(i) ^ 8'h3C);
      idle(7);
    end
    waitDone(d0 + 1, "short_done_count");
    waitIdle("idle_after_short");
    check("short_writes", rises - r0, 50 + LinePixels);
    check("short_flips", flips - f0, 1);
    check("short_flip_level", int'(FlipBuffer), 1);
    check("short_overflow", int'(overflow), 0);
    check("short_pending", expQ.size(), 0);

    // line_start together with a pixel while the index sits at 37.
    doReset();
    f0 = flips;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 37; i++) begin
      expectWrite(i, 8'(i));
      drive(1'b0, 1'b1, 8'(i));
      idle(7);
    end
    check("simul_lost_before", int'(line_lost), 0);
    expectWrite(0, 8'hA5);
    drive(1'b1, 1'b1, 8'hA5);
    waitIdle("idle_after_simul");
    check("simul_line_lost", int'(line_lost), 1);
    check("simul_overflow", int'(overflow), 0);
    check("simul_no_flip", flips - f0, 0);
    check("simul_pending", expQ.size(), 0);

    // Reset in the second REQ cycle of the second write, five entries still queued.
    doReset();
    r0 = rises;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      expectWrite(i, 8'(8'h10 + i));
      drive(1'b0, 1'b1, 8'(8'h10 + i));
    end
    n = 0;
    while (rises < r0 + 2 && n < 100) begin
      idle(1);
      n++;
    end
    check("midreq_second_write_seen", rises - r0, 2);
    reset = 1'b1;
    idle(1);
    check("midreq_req_low", int'(RequestWriteBuffer), 0);
    check("midreq_flip_low", int'(FlipBuffer), 0);
    check("midreq_busy_low", int'(busy), 0);
    check("midreq_unwritten", expQ.size(), 5);
    expQ.delete();
    idle(1);
    reset = 1'b0;
    idle(40);
    check("midreq_no_more_writes", rises - r0, 2);
    check("midreq_busy_after", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
